// File: rtl/cla64_pkg.sv
// rtl/cla64_pkg.sv - shared widths, FSM states and 4-bit lookahead cell for the cla64 stream block
package cla64_pkg;

  localparam int DATA_W     = 64;
  localparam int DEF_WORD_W = 16;
  localparam int NWORDS     = DATA_W / DEF_WORD_W;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ADD    = 2'd2,
    SEND   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] c;
    logic       pg;
    logic       gg;
  } la4_t;

  // c[i] is the carry into position i; pg/gg are the group terms and ignore ci
  function automatic la4_t la4(input logic [3:0] p, input logic [3:0] g, input logic ci);
    la4_t r;
    r.c[0] = ci;
    r.c[1] = g[0] | (p[0] & ci);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    r.pg   = &p;
    r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/cla64_stream_if_cla.sv
// rtl/cla64_stream_if_cla.sv - combinational 64-bit three-level carry-lookahead adder (cla_64bit)
module cla_64bit
  import cla64_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] s,
  output logic        p0,
  output logic        g0,
  output logic        cout
);

  logic [63:0] p, g, c;
  logic [15:0] p1, g1, c1;
  logic [3:0]  p2, g2, c2;
  la4_t        t;

  always_comb begin
    t  = '0;
    p  = a | b;
    g  = a & b;
    p1 = '0; g1 = '0; c1 = '0;
    p2 = '0; g2 = '0; c2 = '0;
    c  = '0;
    // group terms bottom-up, then carries top-down
    for (int i = 0; i < 16; i++) begin
      t = la4(p[4*i +: 4], g[4*i +: 4], 1'b0);
      p1[i] = t.pg;
      g1[i] = t.gg;
    end
    for (int j = 0; j < 4; j++) begin
      t = la4(p1[4*j +: 4], g1[4*j +: 4], 1'b0);
      p2[j] = t.pg;
      g2[j] = t.gg;
    end
    t    = la4(p2, g2, cin);
    c2   = t.c;
    p0   = t.pg;
    g0   = t.gg;
    cout = t.gg | (t.pg & cin);
    for (int j = 0; j < 4; j++) begin
      t = la4(p1[4*j +: 4], g1[4*j +: 4], c2[j]);
      c1[4*j +: 4] = t.c;
    end
    for (int i = 0; i < 16; i++) begin
      t = la4(p[4*i +: 4], g[4*i +: 4], c1[i]);
      c[4*i +: 4] = t.c;
    end
    s = a ^ b ^ c;
  end

endmodule

// File: rtl/cla64_stream_if.sv
// rtl/cla64_stream_if.sv - word-serial load of a/b, one-cycle registered add, word-serial result send
module cla64_stream_if
  import cla64_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_p,
  output logic              out_g,
  output logic              out_ovf,
  output logic              out_zero
);

  localparam int NW = DATA_W / WORD_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] a, b, s_r, s;
  logic              cin_r, cla_p, cla_g, cla_cout;
  logic              in_fire, out_fire, last_word;

  cla_64bit u_cla (
    .a    (a),
    .b    (b),
    .cin  (cin_r),
    .s    (s),
    .p0   (cla_p),
    .g0   (cla_g),
    .cout (cla_cout)
  );

  assign last_word = (cnt == CW'(NW - 1));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? s_r[int'(cnt)*WORD_W +: WORD_W] : '0;
  assign out_last  = out_valid && last_word;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_n;
  end

  // in_ready is gated by rst_n so nothing is offered as accepted while reset is held
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = rst_n;
        if (in_valid && rst_n && last_word) state_n = LOAD_B;
      end
      LOAD_B: begin
        in_ready = rst_n;
        if (in_valid && rst_n && last_word) state_n = ADD;
      end
      ADD:     state_n = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && last_word) state_n = LOAD_A;
      end
      default: state_n = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      a        <= '0;
      b        <= '0;
      s_r      <= '0;
      cin_r    <= 1'b0;
      out_cout <= 1'b0;
      out_p    <= 1'b0;
      out_g    <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      if (in_fire || out_fire) cnt <= last_word ? '0 : cnt + 1'b1;
      if (in_fire && state == LOAD_A) begin
        a[int'(cnt)*WORD_W +: WORD_W] <= in_data;
        if (cnt == '0) cin_r <= in_cin;
      end
      if (in_fire && state == LOAD_B) b[int'(cnt)*WORD_W +: WORD_W] <= in_data;
      if (state == ADD) begin
        s_r      <= s;
        out_cout <= cla_cout;
        out_p    <= cla_p;
        out_g    <= cla_g;
        out_ovf  <= (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
        out_zero <= (s == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla64_stream_if.sv
// tb/tb_cla64_stream_if.sv - randomized stream bench with arithmetic reference model for cla64_stream_if
module tb_cla64_stream_if;

  localparam int W  = 16;
  localparam int NW = 64 / W;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_cin;
  logic         out_valid, out_ready, out_last;
  logic         out_cout, out_p, out_g, out_ovf, out_zero;
  logic [W-1:0] in_data, out_data;

  always #5 clk = ~clk;

  cla64_stream_if #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_p     (out_p),
    .out_g     (out_g),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [63:0] s;
    logic        cout, p, g, ovf, zero;
  } res_t;

  typedef struct {
    res_t r;
    int   t_acc;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  int          cmp_idx = 0, gmode = 0, rmode = 0, held = 0;
  bit          started = 0, hold_valid = 0;
  logic [W-1:0] hold_data;
  logic        hold_last;
  res_t        last_r = '{default: '0};
  res_t        cur;
  logic [63:0] cur_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic c);
    res_t        r;
    logic [64:0] t, t0;
    t      = {1'b0, a} + {1'b0, b} + {64'd0, c};
    t0     = {1'b0, a} + {1'b0, b};
    r.s    = t[63:0];
    r.cout = t[64];
    r.p    = &(a | b);
    r.g    = t0[64];
    r.ovf  = (a[63] == b[63]) && (r.s[63] != a[63]);
    r.zero = (r.s == 64'd0);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // single compare process: every negedge, outputs vs the head of the expected queue
  always @(negedge clk) begin
    if (!rst_n) begin
      if (cyc > 0) begin
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
      end
      cmp_idx = 0; started = 0; hold_valid = 0;
      last_r = '{default: '0};
    end else if (out_valid) begin
      check("excl_in_ready", 64'(in_ready), 64'd0);
      if (expq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        cur   = expq[0].r;
        cur_s = cur.s;
        if (!started) begin
          check("latency", 64'(cyc), 64'(expq[0].t_acc + 2));
          started = 1;
        end
        check("out_data", 64'(out_data), 64'(cur_s[cmp_idx*W +: W]));
        check("out_last", 64'(out_last), 64'(cmp_idx == NW - 1));
        check("flags", 64'({out_cout, out_p, out_g, out_ovf, out_zero}),
              64'({cur.cout, cur.p, cur.g, cur.ovf, cur.zero}));
        if (hold_valid)
          check("bp_stable", 64'({out_data, out_last}), 64'({hold_data, hold_last}));
        if (out_ready) begin
          hold_valid = 0;
          cmp_idx++;
          if (cmp_idx == NW) begin
            last_r = cur;
            void'(expq.pop_front());
            cmp_idx = 0;
            started = 0;
          end
        end else begin
          hold_valid = 1;
          hold_data  = out_data;
          hold_last  = out_last;
        end
      end
    end else begin
      if (hold_valid) begin
        n_cmp++; n_bad++;
        $display("FAIL valid_dropped: got 0 expected 1 (cycle %0d)", cyc);
        hold_valid = 0;
      end
      if (cyc > 0)
        check("flags_hold", 64'({out_cout, out_p, out_g, out_ovf, out_zero}),
              64'({last_r.cout, last_r.p, last_r.g, last_r.ovf, last_r.zero}));
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: if (out_valid && cmp_idx == 2 && held < 3) begin
             out_ready = 1'b0;
             held++;
           end else out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send_word(input logic [W-1:0] w, input logic c, input bit push, input res_t r);
    int   n, waited;
    bit   acc;
    exp_t e;
    n = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_cin   = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = w; in_cin = c;
    waited = 0; acc = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && push) begin
        e.r = r; e.t_acc = cyc;
        expq.push_back(e);
      end
      @(posedge clk); #1;
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          n_cmp++; n_bad++;
          $display("FAIL in_accept_timeout: got no in_ready expected in_ready within 200 cycles");
          acc = 1;
        end
      end
    end
  endtask

  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic c);
    res_t r;
    r = model(a, b, c);
    for (int i = 0; i < NW; i++) send_word(a[i*W +: W], (i == 0) ? c : 1'($urandom), 0, r);
    for (int i = 0; i < NW; i++) send_word(b[i*W +: W], 1'($urandom), (i == NW - 1), r);
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0;
    k = 0;
    while (expq.size() != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (expq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", expq.size());
      expq.delete();
    end
  endtask

  initial begin
    res_t        r;
    logic [63:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cin = 1'b0;

    r = model(64'd5, 64'd12, 1'b0);
    check("pin1_s", r.s, 64'h0000_0000_0000_0011);
    check("pin1_flags", 64'({r.cout, r.ovf, r.zero}), 64'd0);
    r = model('1, '1, 1'b1);
    check("pin2_s", r.s, 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin2_flags", 64'({r.cout, r.p, r.g, r.ovf}), 64'b1110);
    r = model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("pin3_s", r.s, 64'h8000_0000_0000_0000);
    check("pin3_flags", 64'({r.cout, r.ovf}), 64'b01);
    r = model(64'd0, 64'd0, 1'b0);
    check("pin4_zero", 64'({r.zero, r.p, r.g}), 64'b100);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out", 64'({out_valid, out_last, out_data}), 64'd0);
    @(posedge clk); #1;

    rmode = 0; gmode = 0;
    run_txn(64'd5, 64'd12, 1'b0);
    run_txn('1, '1, 1'b1);
    run_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    drain();
    held = 0; rmode = 2;
    run_txn(64'd0, 64'd0, 1'b0);
    drain();
    rmode = 0; gmode = 1;
    run_txn(64'd5, 64'd12, 1'b0);
    run_txn(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    drain();

    gmode = 0;
    send_word(16'hAAAA, 1'b1, 0, r);
    send_word(16'hBBBB, 1'b1, 0, r);
    in_valid = 1'b1; in_data = 16'hCCCC;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    run_txn(64'd3, 64'd4, 1'b0);
    drain();

    rmode = 1; gmode = 2;
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: run_txn(ra, ~ra, 1'b1);
        1: run_txn({1'b0, ra[62:0]}, {1'b0, rb[62:0]}, 1'($urandom));
        default: run_txn(ra, rb, 1'($urandom));
      endcase
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
